// File: rtl/qk_seq_pkg.sv
// ============================================================================
// Module      : qk_seq_pkg
// Description : Shared state encoding, inst field positions and widths for
//               the QK sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package qk_seq_pkg;

    localparam int INST_W = 17;
    localparam int ADD_W  = 4;
    localparam int CNT_W  = 8;

    localparam int OFIFO_RD_BIT  = 16;
    localparam int QKMEM_ADD_LSB = 12;
    localparam int PMEM_ADD_LSB  = 8;
    localparam int EXECUTE_BIT   = 7;
    localparam int LOAD_BIT      = 6;
    localparam int QMEM_RD_BIT   = 5;
    localparam int QMEM_WR_BIT   = 4;
    localparam int KMEM_RD_BIT   = 3;
    localparam int KMEM_WR_BIT   = 2;
    localparam int PMEM_RD_BIT   = 1;
    localparam int PMEM_WR_BIT   = 0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_QWR      = 4'd1,
        ST_KWR      = 4'd2,
        ST_LOAD     = 4'd3,
        ST_EXEC     = 4'd4,
        ST_WAIT     = 4'd5,
        ST_DRAIN    = 4'd6,
        ST_READBACK = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

endpackage

`default_nettype wire

// File: rtl/qk_seq_cnt.sv
// ============================================================================
// Module      : qk_seq_cnt
// Description : Loadable phase counter; saturates at limit and flags it on tc.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module qk_seq_cnt
    import qk_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == limit);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/qk_sequencer.sv
// ============================================================================
// Module      : qk_sequencer
// Description : Drives the fullchip inst word through write, load, execute,
//               wait and drain phases. Optional READBACK phase under the
//               macro QK_SEQ_READBACK_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module qk_sequencer
    import qk_seq_pkg::*;
#(
    parameter int bw          = 8,
    parameter int pr          = 16,
    parameter int col         = 8,
    parameter int total_cycle = 8,
    parameter int gap         = 10
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [pr*bw-1:0]    in_data,
    output logic                in_ready,
    output logic [pr*bw-1:0]    mem_in,
    output logic [INST_W-1:0]   inst,
    output logic                busy,
    output logic                done
);

    localparam logic [CNT_W-1:0] LIM_Q    = CNT_W'(total_cycle - 1);
    localparam logic [CNT_W-1:0] LIM_K    = CNT_W'(col - 1);
    localparam logic [CNT_W-1:0] LIM_LOAD = CNT_W'(col + 1);
    localparam logic [CNT_W-1:0] LIM_WAIT = CNT_W'((gap > 0) ? gap - 1 : 0);

    state_t              state;
    state_t              state_next;
    logic [INST_W-1:0]   inst_next;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    limit;
    logic [ADD_W-1:0]    add_cnt;
    logic                tc;
    logic                cnt_load;
    logic                cnt_en;
    logic                accept;

    assign in_ready = (state == ST_QWR) || (state == ST_KWR);
    assign accept   = in_valid && in_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign add_cnt  = count[ADD_W-1:0];

    qk_seq_cnt u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value ('0),
        .enable     (cnt_en),
        .limit      (limit),
        .count      (count),
        .tc         (tc)
    );

    always_comb begin
        state_next = state;
        inst_next  = '0;
        limit      = '0;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_load = 1'b1;
                if (start) state_next = ST_QWR;
            end
            // A bubble keeps the last presented write address on the bus.
            ST_QWR: begin
                limit  = LIM_Q;
                cnt_en = accept;
                inst_next[QMEM_WR_BIT] = accept;
                inst_next[QKMEM_ADD_LSB +: ADD_W] = accept ? add_cnt : inst[QKMEM_ADD_LSB +: ADD_W];
                if (accept && tc) begin
                    state_next = ST_KWR;
                    cnt_load   = 1'b1;
                end
            end
            ST_KWR: begin
                limit  = LIM_K;
                cnt_en = accept;
                inst_next[KMEM_WR_BIT] = accept;
                inst_next[QKMEM_ADD_LSB +: ADD_W] = accept ? add_cnt : inst[QKMEM_ADD_LSB +: ADD_W];
                if (accept && tc) begin
                    state_next = ST_LOAD;
                    cnt_load   = 1'b1;
                end
            end
            ST_LOAD: begin
                limit  = LIM_LOAD;
                cnt_en = 1'b1;
                inst_next[LOAD_BIT] = 1'b1;
                if (count != '0 && !tc) begin
                    inst_next[KMEM_RD_BIT] = 1'b1;
                    inst_next[QKMEM_ADD_LSB +: ADD_W] = add_cnt - 1'b1;
                end
                if (tc) begin
                    state_next = ST_EXEC;
                    cnt_load   = 1'b1;
                end
            end
            ST_EXEC: begin
                limit  = LIM_Q;
                cnt_en = 1'b1;
                inst_next[EXECUTE_BIT] = 1'b1;
                inst_next[QMEM_RD_BIT] = 1'b1;
                inst_next[QKMEM_ADD_LSB +: ADD_W] = add_cnt;
                if (tc) begin
                    state_next = (gap == 0) ? ST_DRAIN : ST_WAIT;
                    cnt_load   = 1'b1;
                end
            end
            ST_WAIT: begin
                limit  = LIM_WAIT;
                cnt_en = 1'b1;
                if (tc) begin
                    state_next = ST_DRAIN;
                    cnt_load   = 1'b1;
                end
            end
            ST_DRAIN: begin
                limit  = LIM_Q;
                cnt_en = 1'b1;
                inst_next[OFIFO_RD_BIT] = 1'b1;
                inst_next[PMEM_WR_BIT]  = 1'b1;
                inst_next[PMEM_ADD_LSB +: ADD_W] = add_cnt;
                if (tc) begin
`ifdef QK_SEQ_READBACK_EN
                    state_next = ST_READBACK;
`else
                    state_next = ST_DONE;
`endif
                    cnt_load   = 1'b1;
                end
            end
`ifdef QK_SEQ_READBACK_EN
            ST_READBACK: begin
                limit  = LIM_Q;
                cnt_en = 1'b1;
                inst_next[PMEM_RD_BIT] = 1'b1;
                inst_next[PMEM_ADD_LSB +: ADD_W] = add_cnt;
                if (tc) begin
                    state_next = ST_DONE;
                    cnt_load   = 1'b1;
                end
            end
`endif
            ST_DONE: begin
                state_next = ST_IDLE;
                cnt_load   = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_load   = 1'b1;
            end
        endcase
        if (abort) begin
            state_next = ST_IDLE;
            inst_next  = '0;
            cnt_load   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            inst   <= '0;
            mem_in <= '0;
        end else begin
            state <= state_next;
            inst  <= inst_next;
            if (accept && !abort) mem_in <= in_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_qk_sequencer.sv
// ============================================================================
// Module      : tb_qk_sequencer
// Description : Scoreboard bench for qk_sequencer (default and minimal configs).
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_qk_sequencer;

    localparam int PR = 16;
    localparam int BW = 8;
    localparam int DW = PR * BW;
    localparam int TC0 = 8, COL0 = 8, GAP0 = 10;
    localparam int TC1 = 1, COL1 = 1, GAP1 = 0;

    localparam int B_OFIFO = 16, B_EXEC = 7, B_LOAD = 6, B_QRD = 5, B_QWR = 4;
    localparam int B_KRD = 3, B_KWR = 2, B_PRD = 1, B_PWR = 0;
    localparam logic [16:0] STROBES = 17'h100FF;

    typedef struct {
        int          cyc;
        logic [16:0] inst;
        logic        done;
        logic        chk;
        logic [DW-1:0] mem;
    } item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    start, abort, in_valid, in_ready, busy, done;
    logic [DW-1:0] in_data [2];
    logic [DW-1:0] mem_in [2];
    logic [16:0]   inst [2];

    item_t q0[$];
    item_t q1[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    qk_sequencer #(.bw(BW), .pr(PR), .col(COL0), .total_cycle(TC0), .gap(GAP0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .abort(abort[0]),
        .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
        .mem_in(mem_in[0]), .inst(inst[0]), .busy(busy[0]), .done(done[0]));

    qk_sequencer #(.bw(BW), .pr(PR), .col(COL1), .total_cycle(TC1), .gap(GAP1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .abort(abort[1]),
        .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
        .mem_in(mem_in[1]), .inst(inst[1]), .busy(busy[1]), .done(done[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int qsize(input int d);
        return (d != 0) ? q1.size() : q0.size();
    endfunction

    function automatic item_t mk(input int c, input logic [16:0] w, input logic dn);
        item_t it;
        it.cyc = c; it.inst = w; it.done = dn; it.chk = 1'b0; it.mem = '0;
        return it;
    endfunction

    task automatic push(input int d, input item_t it);
        if (d != 0) q1.push_back(it);
        else q0.push_back(it);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: every cycle with a strobe or done set consumes one expected item.
    task automatic mon(input int d);
        item_t e;
        checks++;
        if (qsize(d) == 0) begin
            errors++;
            $display("FAIL unexpected_output dut%0d cyc=%0d: got inst=%h done=%b, required no output",
                     d, cyc, inst[d], done[d]);
            return;
        end
        if (d != 0) e = q1.pop_front();
        else e = q0.pop_front();
        if (e.cyc != cyc || e.inst !== inst[d] || e.done !== done[d] || (e.chk && e.mem !== mem_in[d])) begin
            errors++;
            $display("FAIL output dut%0d: got cyc=%0d inst=%h done=%b mem=%h, required cyc=%0d inst=%h done=%b mem=%h",
                     d, cyc, inst[d], done[d], mem_in[d], e.cyc, e.inst, e.done, e.mem);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (((inst[d] & STROBES) != '0) || done[d]) mon(d);
        end
    end

    task automatic wait_q(input int d);
        for (int i = 0; i < 300 && qsize(d) != 0; i++) tick;
        checks++;
        if (qsize(d) != 0) begin
            errors++;
            $display("FAIL timeout dut%0d: got %0d pending outputs, required 0", d, qsize(d));
            if (d != 0) q1.delete(); else q0.delete();
        end
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) tick;
    endtask

    // mode: 0 all valid, 1 Q beats toggle 1,0,1,0 / K all valid, 2 random.
    task automatic run(input int d, input int mode, input int abort_at, input int rst_at);
        int tc, cl, gp, b, k, n, base, ebase, dbase, nx, nd;
        logic v, last;
        logic [16:0] w;
        logic [DW-1:0] dat;
        item_t it;
        tc = (d != 0) ? TC1 : TC0;
        cl = (d != 0) ? COL1 : COL0;
        gp = (d != 0) ? GAP1 : GAP0;
        chk("idle_busy", DW'(busy[d]), DW'(0));
        chk("idle_in_ready", DW'(in_ready[d]), DW'(0));
        start[d] = 1'b1;
        tick;
        start[d] = 1'b0;
        chk("qwr_in_ready", DW'(in_ready[d]), DW'(1));
        chk("qwr_busy", DW'(busy[d]), DW'(1));
        k = 0;
        for (int ph = 0; ph < 2; ph++) begin
            n = (ph != 0) ? cl : tc;
            b = 0;
            while (b < n) begin
                case (mode)
                    0:       v = 1'b1;
                    1:       v = (ph == 0) ? (k % 2 == 0) : 1'b1;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (mode == 2) start[d] = 1'($urandom_range(0, 1));
                dat = {$urandom, $urandom, $urandom, $urandom};
                in_valid[d] = v;
                in_data[d]  = dat;
                if (v) begin
                    w = '0;
                    w[(ph != 0) ? B_KWR : B_QWR] = 1'b1;
                    w[15:12] = 4'(b);
                    it = mk(cyc + 1, w, 1'b0);
                    it.chk = 1'b1;
                    it.mem = dat;
                    push(d, it);
                    b++;
                end
                k++;
                tick;
            end
        end
        start[d] = 1'b0;
        in_valid[d] = 1'($urandom_range(0, 1));
        in_data[d] = {$urandom, $urandom, $urandom, $urandom};
        base = cyc + 1;
        for (int j = 0; j < cl + 2; j++) begin
            w = '0;
            w[B_LOAD] = 1'b1;
            if (j >= 1 && j <= cl) begin
                w[B_KRD] = 1'b1;
                w[15:12] = 4'(j - 1);
            end
            push(d, mk(base + j, w, 1'b0));
        end
        ebase = base + cl + 2;
        nx = (abort_at >= 0) ? abort_at : tc;
        for (int i = 0; i < nx; i++) begin
            w = '0;
            w[B_EXEC] = 1'b1; w[B_QRD] = 1'b1; w[15:12] = 4'(i);
            push(d, mk(ebase + i, w, 1'b0));
        end
        if (abort_at >= 0) begin
            wait_until(ebase + abort_at - 1);
            abort[d] = 1'b1;
            tick;
            abort[d] = 1'b0;
            chk("abort_inst", DW'(inst[d]), DW'(0));
            chk("abort_busy", DW'(busy[d]), DW'(0));
            repeat (60) tick;
            wait_q(d);
            in_valid[d] = 1'b0;
            return;
        end
        dbase = ebase + tc + gp;
        nd = (rst_at >= 0) ? rst_at : tc;
        for (int i = 0; i < nd; i++) begin
            w = '0;
            w[B_OFIFO] = 1'b1; w[B_PWR] = 1'b1; w[11:8] = 4'(i);
            last = (i == tc - 1);
`ifdef QK_SEQ_READBACK_EN
            last = 1'b0;
`endif
            push(d, mk(dbase + i, w, last));
        end
`ifdef QK_SEQ_READBACK_EN
        if (rst_at < 0) begin
            for (int i = 0; i < tc; i++) begin
                w = '0;
                w[B_PRD] = 1'b1; w[11:8] = 4'(i);
                push(d, mk(dbase + tc + i, w, i == tc - 1));
            end
        end
`endif
        if (rst_at >= 0) begin
            wait_until(dbase + rst_at);
            #1;
            reset = 1'b0;
            #1;
            chk("rst_inst", DW'(inst[d]), DW'(0));
            chk("rst_mem_in", mem_in[d], '0);
            chk("rst_busy", DW'(busy[d]), DW'(0));
            chk("rst_done", DW'(done[d]), DW'(0));
            chk("rst_in_ready", DW'(in_ready[d]), DW'(0));
            tick;
            tick;
            reset = 1'b1;
            tick;
        end
        wait_q(d);
        in_valid[d] = 1'b0;
        tick;
        chk("end_busy", DW'(busy[d]), DW'(0));
    endtask

    initial begin
        reset = 1'b0;
        start = '0;
        abort = '0;
        in_valid = '0;
        in_data[0] = '0;
        in_data[1] = '0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_inst", DW'(inst[d]), DW'(0));
            chk("reset_mem_in", mem_in[d], '0);
            chk("reset_busy", DW'(busy[d]), DW'(0));
            chk("reset_done", DW'(done[d]), DW'(0));
        end
        tick;
        tick;
        reset = 1'b1;
        tick;

        run(0, 0, -1, -1);
        run(0, 1, -1, -1);
        run(0, 2, -1, -1);
        run(0, 0, 3, -1);
        // abort outranks start in IDLE
        start[0] = 1'b1;
        abort[0] = 1'b1;
        tick;
        start[0] = 1'b0;
        abort[0] = 1'b0;
        chk("abort_over_start", DW'(busy[0]), DW'(0));
        repeat (5) tick;
        run(0, 0, -1, -1);
        run(0, 2, -1, 2);
        repeat (5) tick;
        chk("post_reset_idle", DW'(busy[0]), DW'(0));
        run(0, 0, -1, -1);
        run(1, 0, -1, -1);
        run(1, 2, -1, -1);
        run(1, 1, -1, -1);
        repeat (5) tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/qk_sequencer.md
QK_SEQUENCER -- requirements
Module: qk_sequencer

Interface
REQ-001 Parameters, one per line:
- bw, 8, Q/K element width.
- pr, 16, elements per vector.
- col, 8, K vectors / dot-product units; 1..16.
- total_cycle, 8, Q vectors per run; 1..16.
- gap, 10, idle cycles between execute and drain; 0..255.

REQ-002 Ports, one per line:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous, active-low.
- start, in, 1, run request, sampled in IDLE.
- abort, in, 1, synchronous cancel.
- in_valid, in, 1, host vector valid.
- in_data, in, pr*bw, host vector (Q vectors first, then K vectors).
- in_ready, out, 1, sequencer accepts in_data this cycle.
- mem_in, out, pr*bw, registered copy of accepted in_data.
- inst, out, 17, fullchip instruction word.
- busy, out, 1, high in every state except IDLE.
- done, out, 1, one-cycle pulse at run end.

Function
REQ-003 inst field map: [16] ofifo_rd, [15:12] qkmem_add, [11:8] pmem_add, [7] execute, [6] load, [5] qmem_rd, [4] qmem_wr, [3] kmem_rd, [2] kmem_wr, [1] pmem_rd, [0] pmem_wr.
REQ-004 inst and mem_in are registered; each is driven one cycle after the state/counter values that produce it.
REQ-005 States: IDLE, QWR, KWR, LOAD, EXEC, WAIT, DRAIN, DONE.
REQ-006 IDLE: inst=0, in_ready=0; start=1 moves to QWR.
REQ-007 QWR: in_ready=1; each in_valid&in_ready beat drives qmem_wr=1, qkmem_add=beat index 0..total_cycle-1, mem_in=in_data; a cycle with in_valid=0 is a bubble with qmem_wr=0 and the address held; the last beat moves to KWR.
REQ-008 KWR: same handshake as QWR, using kmem_wr and col beats; the last beat moves to LOAD.
REQ-009 LOAD lasts col+2 cycles with load=1 throughout:
- cycle 0: kmem_rd=0, qkmem_add=0.
- cycles 1..col: kmem_rd=1, qkmem_add=cycle-1.
- cycle col+1: kmem_rd=0, qkmem_add=0.
REQ-010 EXEC lasts total_cycle cycles: execute=1, qmem_rd=1, qkmem_add=0..total_cycle-1.
REQ-011 WAIT lasts gap cycles with inst=0; gap=0 skips WAIT and goes directly to DRAIN.
REQ-012 DRAIN lasts total_cycle cycles: ofifo_rd=1, pmem_wr=1, pmem_add=0..total_cycle-1.
REQ-013 DONE lasts one cycle: done=1, inst=0, then the state returns to IDLE.
REQ-014 start asserted while busy=1 is ignored.
REQ-015 abort=1 in any state: next state is IDLE, inst=0 on the following cycle, no done pulse, counters cleared; abort has priority over start in the same cycle.
REQ-016 All address fields are 4 bits; counters never exceed the parameter bound minus 1 and do not wrap within a phase.
REQ-017 in_ready=0 in every state except QWR and KWR; in_data is ignored when in_ready=0.

Reset
REQ-018 reset=0 forces asynchronously: state=IDLE, all counters=0, inst=0, mem_in=0, in_ready=0, busy=0, done=0.
REQ-019 A reset asserted mid-run discards the run; after deassertion the block waits in IDLE for a new start.

Configuration
REQ-020 Macro QK_SEQ_READBACK_EN:
- Defined: a READBACK state is inserted between DRAIN and DONE, lasting total_cycle cycles with pmem_rd=1 and pmem_add=0..total_cycle-1, all other inst bits 0.
- Undefined: DRAIN goes directly to DONE and pmem_rd is constant 0.

Structure
REQ-021 Package qk_seq_pkg holds the state enum, the inst bit-position constants and field widths; the block uses these constants for every inst field.
REQ-022 One sub-module, qk_seq_cnt: a loadable phase counter with terminal-count output, instantiated once and reused across all phases.

Verification
REQ-023 Scenarios the bench shall cover:
- Reset then start with all defaults and in_valid held high: 8 QWR beats with qkmem_add 0..7, 8 KWR beats, LOAD for 10 cycles with kmem_rd high for 8 of them, EXEC for 8 cycles, WAIT for 10 cycles, DRAIN for 8 cycles, done high at cycle 53 after start (±1 per registration).
- in_valid toggled 1,0,1,0 during QWR: qmem_wr mirrors in_valid, qkmem_add advances only on accepted beats, mem_in equals each accepted vector.
- abort pulsed during EXEC cycle 3: inst=0 next cycle, busy=0, done never pulses, and a new start runs a full sequence.
- reset=0 during DRAIN: all outputs 0 immediately without waiting for a clock edge.
- gap=0 with total_cycle=1 and col=1: EXEC followed directly by DRAIN; every phase lasts its minimum length.
- QK_SEQ_READBACK_EN defined: 8 cycles of pmem_rd=1 with pmem_add 0..7 after DRAIN; with the macro undefined, pmem_rd stays 0 throughout.
